// File: rtl/mips_bus_mem_responder.sv
// Avalon-style memory slave for mips_cpu_bus benches: instruction region at the reset vector,
// data region at address 0, with fixed and optionally LFSR-randomised waitrequest stalls.
module mips_bus_mem_responder #(
    parameter string       INSTR_INIT_FILE = "",
    parameter string       DATA_INIT_FILE  = "",
    parameter int unsigned INSTR_WORDS     = 1024,
    parameter int unsigned DATA_WORDS      = 1024,
    parameter int unsigned WAIT_CYCLES     = 2,
    parameter bit          RANDOM_WAIT     = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_address,
    input  logic        i_write,
    input  logic        i_read,
    output logic        o_waitrequest,
    input  logic [31:0] i_writedata,
    input  logic [3:0]  i_byteenable,
    output logic [31:0] o_readdata,
    output logic        o_protocol_error
);

    localparam int unsigned IAW = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;
    localparam int unsigned DAW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
    localparam int unsigned CntW = $clog2(WAIT_CYCLES + 4) + 1;
    localparam logic [29:0] InstrBaseW  = 30'h2FF0_0000;
    localparam logic [29:0] InstrWordsW = 30'(INSTR_WORDS);
    localparam logic [29:0] DataWordsW  = 30'(DATA_WORDS);

    typedef enum logic [1:0] {StIdle, StStall, StAck} state_e;

    logic [31:0] r_instr_mem [INSTR_WORDS];
    logic [31:0] r_data_mem  [DATA_WORDS];

    initial begin
        for (int i = 0; i < INSTR_WORDS; i++) r_instr_mem[i] = 32'h0;
        for (int i = 0; i < DATA_WORDS; i++) r_data_mem[i] = 32'h0;
    end

    state_e          r_state, w_state_d;
    logic [CntW-1:0] r_count, w_count_d;
    logic [29:0]     r_addr, w_addr_d;
    logic [31:0]     r_wdata, w_wdata_d;
    logic [3:0]      r_be, w_be_d;
    logic            r_is_wr, w_is_wr_d;
    logic [31:0]     r_rdata, w_rdata_d;
    logic            r_perr, w_perr_d;
    logic [7:0]      r_lfsr, w_lfsr_d;

    logic            w_req;
    logic            w_commit;
    logic [1:0]      w_extra;
    logic [CntW-1:0] w_load_cnt;
    logic [29:0]     w_rd_word, w_rd_iofs, w_wr_iofs;
    logic [31:0]     w_rd_data;
    logic            w_wr_instr, w_wr_dmem;
    logic            w_unused;

    assign w_unused      = ^i_address[1:0];
    assign w_req         = i_read | i_write;
    assign o_waitrequest = w_req && (r_state != StAck);
    assign o_readdata    = r_rdata;
    assign o_protocol_error = r_perr;

    assign w_extra    = RANDOM_WAIT ? r_lfsr[1:0] : 2'b00;
    assign w_load_cnt = CntW'(WAIT_CYCLES) + CntW'(w_extra);

    // With a zero stall count the read happens straight from IDLE, so use the live address.
    assign w_rd_word = (r_state == StIdle) ? i_address[31:2] : r_addr;
    assign w_rd_iofs = w_rd_word - InstrBaseW;

    always_comb begin
        w_rd_data = '0;
        if (w_rd_iofs < InstrWordsW) begin
            w_rd_data = r_instr_mem[w_rd_iofs[IAW-1:0]];
        end else if (w_rd_word < DataWordsW) begin
            w_rd_data = r_data_mem[w_rd_word[DAW-1:0]];
        end
    end

    assign w_wr_iofs  = r_addr - InstrBaseW;
    assign w_wr_instr = w_wr_iofs < InstrWordsW;
    assign w_wr_dmem  = !w_wr_instr && (r_addr < DataWordsW);

    always_comb begin
        w_state_d = r_state;
        w_count_d = r_count;
        w_addr_d  = r_addr;
        w_wdata_d = r_wdata;
        w_be_d    = r_be;
        w_is_wr_d = r_is_wr;
        w_rdata_d = r_rdata;
        w_perr_d  = r_perr;
        w_lfsr_d  = r_lfsr;
        w_commit  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_req) begin
                    w_addr_d  = i_address[31:2];
                    w_wdata_d = i_writedata;
                    w_be_d    = i_byteenable;
                    w_is_wr_d = i_write;
                    w_lfsr_d  = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
                    w_count_d = w_load_cnt;
                    if (i_read && i_write) w_perr_d = 1'b1;
                    if (w_load_cnt != '0) begin
                        w_state_d = StStall;
                    end else begin
                        w_state_d = StAck;
                        if (!i_write) w_rdata_d = w_rd_data;
                    end
                end
            end
            StStall: begin
                if (!w_req) begin
                    w_state_d = StIdle;
                    w_perr_d  = 1'b1;
                end else begin
                    if ((i_address[31:2] != r_addr) || (i_writedata != r_wdata) ||
                        (i_byteenable != r_be)) begin
                        w_perr_d = 1'b1;
                    end
                    w_count_d = r_count - CntW'(1);
                    if (r_count == CntW'(1)) begin
                        w_state_d = StAck;
                        if (!r_is_wr) w_rdata_d = w_rd_data;
                    end
                end
            end
            StAck: begin
                w_state_d = StIdle;
                if (!w_req) begin
                    w_perr_d = 1'b1;
                end else begin
                    w_commit = r_is_wr;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_count <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_is_wr <= 1'b0;
            r_rdata <= '0;
            r_perr  <= 1'b0;
            r_lfsr  <= 8'hA5;
        end else begin
            r_state <= w_state_d;
            r_count <= w_count_d;
            r_addr  <= w_addr_d;
            r_wdata <= w_wdata_d;
            r_be    <= w_be_d;
            r_is_wr <= w_is_wr_d;
            r_rdata <= w_rdata_d;
            r_perr  <= w_perr_d;
            r_lfsr  <= w_lfsr_d;
        end
    end

    // Reset aborts any in-flight write, so the commit is gated here as well.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    if (w_wr_instr) begin
                        r_instr_mem[w_wr_iofs[IAW-1:0]][8*i +: 8] <= r_wdata[8*i +: 8];
                    end else if (w_wr_dmem) begin
                        r_data_mem[r_addr[DAW-1:0]][8*i +: 8] <= r_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_bus_mem_responder.sv
// Scoreboarded random bench: a fixed-stall responder (index 0) and a random-stall one (index 1).
module tb_mips_bus_mem_responder;

    localparam int unsigned Words = 64;

    logic        clk = 1'b0;
    logic        rst   [2];
    logic        rd    [2];
    logic        wr    [2];
    logic        wreq  [2];
    logic        perr  [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [3:0]  ben   [2];

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    logic [31:0] mdl [bit [30:0]];

    always #5 clk = ~clk;

    mips_bus_mem_responder #(
        .INSTR_INIT_FILE(""), .DATA_INIT_FILE(""), .INSTR_WORDS(Words), .DATA_WORDS(Words),
        .WAIT_CYCLES(2), .RANDOM_WAIT(1'b0)
    ) u_fixed (
        .i_clk(clk), .i_reset(rst[0]), .i_address(addr[0]), .i_write(wr[0]), .i_read(rd[0]),
        .o_waitrequest(wreq[0]), .i_writedata(wdata[0]), .i_byteenable(ben[0]),
        .o_readdata(rdata[0]), .o_protocol_error(perr[0])
    );

    mips_bus_mem_responder #(
        .INSTR_INIT_FILE(""), .DATA_INIT_FILE(""), .INSTR_WORDS(Words), .DATA_WORDS(Words),
        .WAIT_CYCLES(0), .RANDOM_WAIT(1'b1)
    ) u_rand (
        .i_clk(clk), .i_reset(rst[1]), .i_address(addr[1]), .i_write(wr[1]), .i_read(rd[1]),
        .o_waitrequest(wreq[1]), .i_writedata(wdata[1]), .i_byteenable(ben[1]),
        .o_readdata(rdata[1]), .o_protocol_error(perr[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference memory: byte-address ranges, bytes merged per enabled lane.
    function automatic bit mapped(input logic [31:0] a);
        return (a >= 32'hBFC0_0000 && a < 32'hBFC0_0000 + 4 * Words) || (a < 4 * Words);
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
        bit [30:0] key = {d[0], a[31:2]};
        if (mapped(a) && mdl.exists(key)) return mdl[key];
        return 32'h0;
    endfunction

    task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] be);
        bit [30:0]   key = {d[0], a[31:2]};
        logic [31:0] word;
        if (mapped(a)) begin
            word = mdl.exists(key) ? mdl[key] : 32'h0;
            for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = wd[8*i +: 8];
            mdl[key] = word;
        end
    endtask

    // Monitors: an acknowledged plain read pops the oldest expectation.
    always @(negedge clk) begin
        if (!rst[0] && rd[0] && !wr[0] && !wreq[0]) begin
            if (exp_q0.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL fixed_unexpected_ack: got ack, expected none");
            end else begin
                chk("fixed_readdata", rdata[0], exp_q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst[1] && rd[1] && !wr[1] && !wreq[1]) begin
            if (exp_q1.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL rand_unexpected_ack: got ack, expected none");
            end else begin
                chk("rand_readdata", rdata[1], exp_q1.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the completing edge.
    task automatic xfer(input int d, input bit do_rd, input bit do_wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be, output int lat);
        int n = 0;
        addr[d] = a; wdata[d] = wd; ben[d] = be; rd[d] = do_rd; wr[d] = do_wr;
        @(negedge clk);
        while (wreq[d] && n < 64) begin
            n++;
            @(negedge clk);
        end
        if (wreq[d]) begin
            n_checks++; n_err++;
            $display("FAIL xfer_timeout: got waitrequest stuck, expected release");
        end
        @(posedge clk);
        #1;
        rd[d] = 1'b0; wr[d] = 1'b0;
        lat = n;
    endtask

    task automatic chk_lat(input int d, input int lat);
        if (d == 0) begin
            chk("fixed_stall_len", lat, 3);
        end else begin
            n_checks++;
            if (lat < 1 || lat > 4) begin
                n_err++;
                $display("FAIL rand_stall_len: got %0d, expected 1..4", lat);
            end
        end
    endtask

    task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be);
        int lat;
        model_write(d, a, wd, be);
        xfer(d, 1'b0, 1'b1, a, wd, be, lat);
        chk_lat(d, lat);
    endtask

    task automatic do_read(input int d, input logic [31:0] a, input logic [31:0] exp,
                           output int lat);
        if (d == 0) exp_q0.push_back(exp); else exp_q1.push_back(exp);
        xfer(d, 1'b1, 1'b0, a, 32'h0, 4'hF, lat);
        chk_lat(d, lat);
    endtask

    task automatic pulse_reset(input int d);
        rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0;
        @(posedge clk);
        #1;
        rst[d] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1);
    end

    initial begin
        int          lat;
        int          n;
        int          idx  [256];
        int          lat1 [256];
        int          nd;
        bit          seen [5];
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0;
            addr[d] = '0; wdata[d] = '0; ben[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_waitrequest", wreq[d], 0);
            chk("reset_readdata", rdata[d], 32'h0);
            chk("reset_perr", perr[d], 0);
        end
        @(posedge clk);
        #1;

        // Reset-vector fetch with the fixed stall length.
        do_write(0, 32'hBFC0_0000, 32'h8C03_0001, 4'hF);
        do_read(0, 32'hBFC0_0000, 32'h8C03_0001, lat);

        // Partial-lane write.
        do_write(0, 32'h4, 32'h1122_3344, 4'hF);
        do_write(0, 32'h4, 32'hDEAD_BEEF, 4'b0101);
        do_read(0, 32'h4, 32'h11AD_33EF, lat);

        // Unmapped space reads zero and swallows writes.
        do_read(0, 32'h8000_0000, 32'h0, lat);
        do_write(0, 32'h8000_0000, 32'h1234_5678, 4'hF);
        do_read(0, 32'h8000_0000, 32'h0, lat);
        @(negedge clk);
        chk("unmapped_perr", perr[0], 0);
        @(posedge clk);
        #1;

        // Read dropped mid-stall.
        addr[0] = 32'h8; rd[0] = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rd[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_perr", perr[0], 1);
        chk("abort_waitrequest", wreq[0], 0);
        @(posedge clk);
        #1;
        do_write(0, 32'h8, 32'hCAFE_F00D, 4'hF);
        do_read(0, 32'h8, 32'hCAFE_F00D, lat);

        // Reset during a write stall: nothing committed.
        addr[0] = 32'h8; wdata[0] = 32'h55AA_55AA; ben[0] = 4'hF; wr[0] = 1'b1;
        @(posedge clk);
        #1;
        pulse_reset(0);
        @(negedge clk);
        chk("midreset_waitrequest", wreq[0], 0);
        chk("midreset_readdata", rdata[0], 32'h0);
        chk("midreset_perr", perr[0], 0);
        @(posedge clk);
        #1;
        do_read(0, 32'h8, 32'hCAFE_F00D, lat);

        // read and write together act as a write.
        model_write(0, 32'hC, 32'hAABB_CCDD, 4'hF);
        xfer(0, 1'b1, 1'b1, 32'hC, 32'hAABB_CCDD, 4'hF, lat);
        chk_lat(0, lat);
        @(negedge clk);
        chk("both_perr", perr[0], 1);
        @(posedge clk);
        #1;
        do_read(0, 32'hC, 32'hAABB_CCDD, lat);

        // Address change mid-stall: latched address wins.
        pulse_reset(0);
        exp_q0.push_back(model_read(0, 32'h4));
        xfer(0, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF, lat);
        chk_lat(0, lat);
        @(negedge clk);
        chk("steady_perr", perr[0], 0);
        @(posedge clk);
        #1;
        exp_q0.push_back(model_read(0, 32'h4));
        addr[0] = 32'h4; rd[0] = 1'b1; wdata[0] = 32'h0; ben[0] = 4'hF;
        @(posedge clk);
        #1;
        addr[0] = 32'h10;
        n = 0;
        @(negedge clk);
        while (wreq[0] && n < 64) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rd[0] = 1'b0;
        @(negedge clk);
        chk("addr_change_perr", perr[0], 1);
        @(posedge clk);
        #1;

        // Random traffic on the fixed-stall responder.
        for (int i = 0; i < 16; i++) do_write(0, 32'(4 * i), $urandom, 4'hF);
        for (int i = 0; i < 8; i++) do_write(0, 32'hBFC0_0000 + 32'(4 * i), $urandom, 4'hF);
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0:       a = 32'(4 * $urandom_range(0, 15));
                1:       a = 32'hBFC0_0000 + 32'(4 * $urandom_range(0, 7));
                default: a = 32'h4000_0000 + 32'(4 * $urandom_range(0, 255));
            endcase
            a[1:0] = 2'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom;
                be = 4'($urandom);
                do_write(0, a, wd, be);
            end else begin
                do_read(0, a, model_read(0, a), lat);
            end
        end

        // Random-stall responder: fill, then two identical read runs from reset.
        for (int i = 0; i < 64; i++) do_write(1, 32'hBFC0_0000 + 32'(4 * i), $urandom, 4'hF);
        pulse_reset(1);
        for (int i = 0; i < 5; i++) seen[i] = 1'b0;
        for (int i = 0; i < 256; i++) begin
            idx[i] = $urandom_range(0, 63);
            a = 32'hBFC0_0000 + 32'(4 * idx[i]);
            do_read(1, a, model_read(1, a), lat);
            lat1[i] = lat;
            if (lat >= 0 && lat <= 4) seen[lat] = 1'b1;
        end
        nd = 0;
        for (int i = 0; i < 5; i++) if (seen[i]) nd++;
        n_checks++;
        if (nd < 2) begin
            n_err++;
            $display("FAIL rand_stall_variety: got %0d distinct lengths, expected >=2", nd);
        end
        pulse_reset(1);
        for (int i = 0; i < 256; i++) begin
            a = 32'hBFC0_0000 + 32'(4 * idx[i]);
            do_read(1, a, model_read(1, a), lat);
            chk("rand_repeat_stall", lat, lat1[i]);
        end

        repeat (2) @(posedge clk);
        chk("fixed_queue_drained", exp_q0.size(), 0);
        chk("rand_queue_drained", exp_q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
